hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, number of cycles to drain MEM/WB after halt reaches EX/MEM (legal 1..7).
REQ-002 Parameter PERF_W, default 16, width of stall performance counter.
REQ-003 CLK  in  1  single clock, all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 ihit  in  1  instruction fetch complete this cycle.
REQ-006 dhit  in  1  data access complete this cycle.
REQ-007 ifid_rs, ifid_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-008 idex_memread  in  1  instruction in ID/EX is a load; idex_rt  in  5  its destination.
REQ-009 exmem_dren, exmem_dwen  in  1 each  EX/MEM holds a load / store.
REQ-010 exmem_redirect  in  1  taken branch, jump, JR or JAL resolved in EX/MEM.
REQ-011 exmem_halt  in  1  halt instruction in EX/MEM.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register/latch load enables.
REQ-013 ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (all-zero) into latch on next edge.
REQ-014 halt  out  1  processor halted (sticky), drives datapath halt.
REQ-015 ctrl_state  out  3  current FSM state encoding; stall_cnt  out  PERF_W  stalled-cycle count.

Function
REQ-016 FSM states RUN, MEMWAIT, FLUSH, DRAIN, HALTED; all outputs combinational from state and inputs except halt, ctrl_state and stall_cnt, which are registered.
REQ-017 Priority within a cycle, highest first: HALTED, DRAIN, memory wait, redirect, load-use, fetch miss.
REQ-018 Memory wait (exmem_dren|exmem_dwen, dhit=0, state RUN/MEMWAIT/FLUSH): all five enables 0, no flushes; next state MEMWAIT.
REQ-019 MEMWAIT with dhit=1: all enables 1 that cycle, then evaluate redirect/load-use normally; next state RUN (or FLUSH if exmem_redirect).
REQ-020 Redirect (exmem_redirect=1, no memory wait): pc_en=1, ifid_flush=idex_flush=exmem_flush=1, memwb_en=1; next state FLUSH.
REQ-021 FLUSH lasts exactly one cycle; load-use detection suppressed in FLUSH (IF/ID holds a squashed slot); then RUN.
REQ-022 Load-use: idex_memread=1, idex_rt!=0, idex_rt equals ifid_rs or ifid_rt -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stays RUN.
REQ-023 Fetch miss (ihit=0, no higher event): pc_en=0, ifid_flush=1, others enabled (older instructions keep flowing).
REQ-024 exmem_halt=1 (no memory wait): pc_en=0, ifid_flush, idex_flush, exmem_flush=1, memwb_en=1; load drain counter with DRAIN_CYCLES-1; next state DRAIN.
REQ-025 DRAIN: same outputs as REQ-024; counter decrements; at 0 next state HALTED; redirect and load-use ignored.
REQ-026 HALTED: all enables 0, all flushes 0, halt=1, held until RST.
REQ-027 halt=1 from the first cycle in HALTED onward, never earlier.
REQ-028 stall_cnt increments by 1 each cycle pc_en=0 in RUN, MEMWAIT or FLUSH; saturates at all-ones; not incremented in DRAIN/HALTED.
REQ-029 Redirect and memory wait simultaneous: memory wait wins; redirect re-evaluated when dhit arrives (inputs held by frozen latches).

Reset
REQ-030 RST=1 at an edge: state RUN, drain counter 0, halt=0, stall_cnt=0.
REQ-031 While RST=1: all enables 0, all flushes 1, regardless of other inputs; RST mid-DRAIN or mid-MEMWAIT aborts immediately.

Structure
REQ-032 State enum (ctrl_state_t, 3 bits: RUN=0, MEMWAIT=1, FLUSH=2, DRAIN=3, HALTED=4) in cpu_types_pkg.
REQ-033 Load-use comparator in sub-module load_use_detect (combinational, inputs idex_memread, idex_rt, ifid_rs, ifid_rt; output stall).

Verification
REQ-034 Load r2 in ID/EX, IF/ID reads rs=2 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-035 Store in EX/MEM, dhit low 3 cycles -> all enables 0 for 3 cycles, state MEMWAIT; 4th cycle dhit=1 -> enables 1, state RUN; stall_cnt=3.
REQ-036 exmem_redirect=1 with load-use also true -> three flushes, pc_en=1, no load-use stall; next cycle state FLUSH, following RUN.
REQ-037 exmem_halt=1, DRAIN_CYCLES=2 -> DRAIN 1 cycle after, HALTED 2 cycles after, halt=1 thereafter; enables 0 in HALTED.
REQ-038 RST asserted during DRAIN -> next state RUN, halt=0, stall_cnt=0; all flushes 1 while RST high.
REQ-039 idex_rt=0 load with ifid_rs=0 -> no stall.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types for the CPU slice.
//   ctrl_state_t : hazard sequencer FSM state, 3-bit encoding visible on
//                  the ctrl_state debug port.
//   DRAIN_CNT_W  : width of the post-halt drain counter (covers 1..7).
package cpu_types_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        MEMWAIT = 3'd1,
        FLUSH   = 3'd2,
        DRAIN   = 3'd3,
        HALTED  = 3'd4
    } ctrl_state_t;

    localparam int unsigned DRAIN_CNT_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator (purely combinational).
//   idex_memread : instruction in ID/EX is a load
//   idex_rt      : destination register of that load
//   ifid_rs/rt   : source registers of the instruction in IF/ID
//   stall        : IF/ID consumes the load result next cycle
// Register 0 is hardwired to zero, so a load into r0 never creates a hazard.
module load_use_detect (
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       stall
);

    always_comb begin
        stall = idex_memread && (idex_rt != '0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer for the five-stage CPU.
// Inputs : CLK, RST (sync, active-high), ihit/dhit (memory handshakes),
//          IF/ID + ID/EX register fields for load-use detection,
//          EX/MEM event flags (dren, dwen, redirect, halt).
// Outputs: per-latch load enables and bubble flushes (combinational),
//          halt (sticky), ctrl_state and stall_cnt (registered).
// Priority, highest first: HALTED, DRAIN, memory wait, halt entry,
// redirect, load-use, fetch miss.
module hazard_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned PERF_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              idex_memread,
    input  logic [4:0]        idex_rt,
    input  logic              exmem_dren,
    input  logic              exmem_dwen,
    input  logic              exmem_redirect,
    input  logic              exmem_halt,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              halt,
    output logic [2:0]        ctrl_state,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_t            state, state_nxt;
    logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_nxt;
    logic                   load_use;
    logic                   mem_wait;
    logic                   stall_window;

    load_use_detect u_load_use_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .stall        (load_use)
    );

    always_comb begin
        mem_wait     = (exmem_dren || exmem_dwen) && !dhit;
        stall_window = (state != DRAIN) && (state != HALTED);
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;

        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                HALTED: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                DRAIN: begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    // The halt-entry cycle already counts as the first
                    // drain cycle, so leave once the counter runs out.
                    if (drain_cnt <= DRAIN_CNT_W'(1)) begin
                        state_nxt     = HALTED;
                        drain_cnt_nxt = '0;
                    end else begin
                        drain_cnt_nxt = drain_cnt - DRAIN_CNT_W'(1);
                    end
                end
                default: begin
                    // RUN, MEMWAIT and FLUSH share one decision tree; the
                    // only state-specific detail is load-use suppression
                    // in FLUSH, where IF/ID holds a squashed slot.
                    state_nxt = RUN;
                    if (mem_wait) begin
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_en  = 1'b0;
                        memwb_en  = 1'b0;
                        state_nxt = MEMWAIT;
                    end else if (exmem_halt) begin
                        pc_en         = 1'b0;
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        exmem_flush   = 1'b1;
                        drain_cnt_nxt = DRAIN_LOAD;
                        state_nxt     = DRAIN;
                    end else if (exmem_redirect) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_nxt   = FLUSH;
                    end else if (load_use && (state != FLUSH)) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            halt      <= (state_nxt == HALTED);
            if (!pc_en && stall_window && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

    always_comb begin
        ctrl_state = state;
    end

endmodule
